hook_ctrl: RTL and testbench

HOOK_CTRL -- requirements
Module: hook_ctrl

---
 rtl/hook_pkg.sv | 19 +
 rtl/hook_if.sv | 23 ++
 rtl/rise_detect.sv | 26 ++
 rtl/hook_ctrl.sv | 104 ++++++++++
 tb/tb_hook_ctrl.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/hook_pkg.sv
// Shared constants and state encoding for the hook controller and its neighbours.
package hook_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_EXTEND   = 2'd1,
    ST_RETRACT  = 2'd2,
    ST_COOLDOWN = 2'd3
  } hook_state_e;

  localparam logic [8:0] DEF_HOOK_BASE   = 9'd43;
  localparam logic [8:0] DEF_HOOK_MAX    = 9'd255;
  localparam logic [3:0] DEF_HOOK_V      = 4'd6;
  localparam logic [5:0] DEF_COOL_FRAMES = 6'd30;

  // Right screen edge, also used by poro_pos.
  localparam logic [8:0] SCREEN_X_MAX    = 9'd319;

endpackage

// File: rtl/hook_if.sv
// Game-side signal bundle of the hook controller: frame/key/hold/poro in, hook status out.
interface hook_if;

  logic       frame;
  logic       fire;
  logic       hold;
  logic [8:0] poro_x;
  logic       grab_success;
  logic [8:0] hook_x;
  logic       busy;
  logic [7:0] grab_count;

  modport master (
    output frame, fire, hold, poro_x,
    input  grab_success, hook_x, busy, grab_count
  );

  modport slave (
    input  frame, fire, hold, poro_x,
    output grab_success, hook_x, busy, grab_count
  );

endinterface

// File: rtl/rise_detect.sv
// Registered rising-edge detector for synchronous key inputs.
// The first sample after reset only primes the history, so a key held through reset never fires.
module rise_detect (
    input  logic clk,
    input  logic resetn,
    input  logic d_i,
    output logic rise_o
);

    logic d_q;
    logic armed_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            d_q     <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            d_q     <= d_i;
            armed_q <= 1'b1;
        end
    end

    assign rise_o = armed_q & d_i & ~d_q;

endmodule

// File: rtl/hook_ctrl.sv
// Hook shot controller: extends the tip each frame, grabs the poro on contact,
// retracts to the rest position and then locks out further shots for a cooldown period.
module hook_ctrl
    import hook_pkg::*;
#(
    parameter logic [8:0] HOOK_BASE   = DEF_HOOK_BASE,
    parameter logic [8:0] HOOK_MAX    = DEF_HOOK_MAX,
    parameter logic [3:0] HOOK_V      = DEF_HOOK_V,
    parameter logic [5:0] COOL_FRAMES = DEF_COOL_FRAMES
) (
    input  logic      clk,
    input  logic      resetn,
    hook_if.slave     bus
);

    hook_state_e state_q;
    logic [8:0]  hook_x_q;
    logic [5:0]  cool_q;
    logic        grab_success_q;
    logic [7:0]  grab_count_q;

    logic        fire_rise;
    logic [9:0]  ext_sum;
    logic [8:0]  ext_nxt;
    logic [9:0]  ret_floor;
    logic [8:0]  ret_nxt;
    logic        hit;

    rise_detect u_fire_rise (
        .clk    (clk),
        .resetn (resetn),
        .d_i    (bus.fire),
        .rise_o (fire_rise)
    );

    // Clamps are evaluated 10 bits wide so neither direction can wrap.
    assign ext_sum   = {1'b0, hook_x_q} + {6'd0, HOOK_V};
    assign ext_nxt   = (ext_sum > {1'b0, HOOK_MAX}) ? HOOK_MAX : ext_sum[8:0];
    assign ret_floor = {1'b0, HOOK_BASE} + {6'd0, HOOK_V};
    assign ret_nxt   = ({1'b0, hook_x_q} >= ret_floor) ? (hook_x_q - {5'd0, HOOK_V}) : HOOK_BASE;
    assign hit       = (ext_nxt >= bus.poro_x) && (bus.poro_x >= HOOK_BASE);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q        <= ST_IDLE;
            hook_x_q       <= HOOK_BASE;
            cool_q         <= 6'd0;
            grab_success_q <= 1'b0;
            grab_count_q   <= 8'd0;
        end else begin
            grab_success_q <= 1'b0;
            if (bus.hold) begin
                state_q  <= ST_IDLE;
                hook_x_q <= HOOK_BASE;
                cool_q   <= 6'd0;
            end else begin
                unique case (state_q)
                    ST_IDLE: begin
                        if (fire_rise) state_q <= ST_EXTEND;
                    end
                    ST_EXTEND: begin
                        if (bus.frame) begin
                            hook_x_q <= ext_nxt;
                            // A hit on the last reachable pixel still counts as a hit.
                            if (hit) begin
                                grab_success_q <= 1'b1;
                                if (grab_count_q != 8'hFF) grab_count_q <= grab_count_q + 8'd1;
                                state_q <= ST_RETRACT;
                            end else if (ext_nxt == HOOK_MAX) begin
                                state_q <= ST_RETRACT;
                            end
                        end
                    end
                    ST_RETRACT: begin
                        if (bus.frame) begin
                            hook_x_q <= ret_nxt;
                            if (ret_nxt == HOOK_BASE) begin
                                cool_q  <= COOL_FRAMES;
                                state_q <= ST_COOLDOWN;
                            end
                        end
                    end
                    ST_COOLDOWN: begin
                        if (bus.frame) begin
                            if (cool_q <= 6'd1) begin
                                cool_q  <= 6'd0;
                                state_q <= ST_IDLE;
                            end else begin
                                cool_q <= cool_q - 6'd1;
                            end
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign bus.grab_success = grab_success_q;
    assign bus.hook_x       = hook_x_q;
    assign bus.busy         = (state_q != ST_IDLE);
    assign bus.grab_count   = grab_count_q;

endmodule

// File: tb/tb_hook_ctrl.sv
// Self-checking bench for hook_ctrl: scripted shots, a pulse scoreboard and boundary scenarios.
module tb_hook_ctrl;

    logic clk    = 1'b0;
    logic resetn = 1'b0;

    always #5 clk = ~clk;

    hook_if u_if ();

    hook_ctrl u_dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (u_if.slave)
    );

    int   n_checks = 0;
    int   n_fail   = 0;
    int   pulse_q[$];
    logic prev_gs  = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    // Each grab pulse pops the grab_count the stimulus predicted for it.
    always @(negedge clk) begin
        if (resetn && u_if.grab_success === 1'b1) begin
            check("gs_double", {31'd0, prev_gs}, 0);
            if (pulse_q.size() == 0) check("gs_unexpected", 1, 0);
            else check("gs_count", {24'd0, u_if.grab_count}, pulse_q.pop_front());
        end
        prev_gs <= u_if.grab_success;
    end

    task automatic frame_step();
        @(negedge clk) u_if.frame = 1'b1;
        @(negedge clk) u_if.frame = 1'b0;
    endtask

    task automatic press_fire();
        @(negedge clk) u_if.fire = 1'b1;
        @(negedge clk) u_if.fire = 1'b0;
    endtask

    task automatic idle_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_hold();
        @(negedge clk) u_if.hold = 1'b1;
        @(negedge clk) u_if.hold = 1'b0;
    endtask

    task automatic run_to_idle(input string tag, output int frames);
        frames = 0;
        while (u_if.busy === 1'b1 && frames < 100) begin
            frame_step();
            frames++;
        end
        check(tag, {31'd0, u_if.busy}, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        u_if.frame  = 1'b0;
        u_if.fire   = 1'b0;
        u_if.hold   = 1'b0;
        u_if.poro_x = 9'd80;
        idle_clks(3);
        check("rst_busy",   {31'd0, u_if.busy}, 0);
        check("rst_hook_x", {23'd0, u_if.hook_x}, 43);
        check("rst_gs",     {31'd0, u_if.grab_success}, 0);
        check("rst_count",  {24'd0, u_if.grab_count}, 0);
        resetn = 1'b1;
        idle_clks(2);

        // Hit at poro_x = 80.
        press_fire();
        check("hit_start_busy", {31'd0, u_if.busy}, 1);
        idle_clks(3);
        check("no_frame_hold", {23'd0, u_if.hook_x}, 43);
        for (int k = 1; k <= 7; k++) begin
            if (k == 7) pulse_q.push_back(1);
            frame_step();
            check("hit_ext_tip", {23'd0, u_if.hook_x}, 32'(43 + 6 * k));
        end
        idle_clks(1);
        check("gs_one_clk", {31'd0, u_if.grab_success}, 0);
        check("hit_count", {24'd0, u_if.grab_count}, 1);
        for (int k = 1; k <= 7; k++) begin
            frame_step();
            check("hit_ret_tip", {23'd0, u_if.hook_x}, 32'(85 - 6 * k));
        end
        repeat (29) frame_step();
        check("cool_busy_29", {31'd0, u_if.busy}, 1);
        frame_step();
        check("cool_idle_30", {31'd0, u_if.busy}, 0);

        // Miss at poro_x = 300, with fire presses in every busy state.
        u_if.poro_x = 9'd300;
        press_fire();
        for (int k = 1; k <= 35; k++) begin
            frame_step();
            check("miss_ext_tip", {23'd0, u_if.hook_x}, 32'(43 + 6 * k));
            if (k == 10) press_fire();
        end
        frame_step();
        check("miss_clamp", {23'd0, u_if.hook_x}, 255);
        frame_step();
        check("miss_ret_first", {23'd0, u_if.hook_x}, 249);
        press_fire();
        n = 0;
        while (u_if.hook_x !== 9'd43 && n < 60) begin
            frame_step();
            n++;
        end
        check("miss_ret_base", {23'd0, u_if.hook_x}, 43);
        check("miss_ret_frames", 32'(n), 35);
        press_fire();
        run_to_idle("miss_idle", n);
        check("miss_cool_frames", 32'(n), 30);
        check("miss_count", {24'd0, u_if.grab_count}, 1);

        // Boundary hit: first frame lands exactly on poro_x.
        u_if.poro_x = 9'd49;
        pulse_q.push_back(2);
        press_fire();
        check("bnd_busy", {31'd0, u_if.busy}, 1);
        frame_step();
        check("bnd_tip", {23'd0, u_if.hook_x}, 49);
        frame_step();
        check("bnd_ret_tip", {23'd0, u_if.hook_x}, 43);
        run_to_idle("bnd_idle", n);
        check("bnd_cool_frames", 32'(n), 30);

        // Hold abort mid-EXTEND at tip 67.
        u_if.poro_x = 9'd300;
        press_fire();
        repeat (4) frame_step();
        check("hold_pre_tip", {23'd0, u_if.hook_x}, 67);
        pulse_hold();
        check("hold_busy",   {31'd0, u_if.busy}, 0);
        check("hold_hook_x", {23'd0, u_if.hook_x}, 43);
        check("hold_count",  {24'd0, u_if.grab_count}, 2);
        @(negedge clk);
        u_if.hold = 1'b1;
        u_if.fire = 1'b1;
        idle_clks(3);
        u_if.hold = 1'b0;
        idle_clks(3);
        check("hold_fire_ignored", {31'd0, u_if.busy}, 0);
        u_if.fire = 1'b0;
        idle_clks(1);

        // Reset mid-RETRACT after a hit at poro_x = 55.
        u_if.poro_x = 9'd55;
        pulse_q.push_back(3);
        press_fire();
        frame_step();
        frame_step();
        frame_step();
        check("rstm_tip", {23'd0, u_if.hook_x}, 49);
        @(negedge clk);
        #1 resetn = 1'b0;
        #1;
        check("rstm_busy",   {31'd0, u_if.busy}, 0);
        check("rstm_hook_x", {23'd0, u_if.hook_x}, 43);
        check("rstm_gs",     {31'd0, u_if.grab_success}, 0);
        check("rstm_count",  {24'd0, u_if.grab_count}, 0);
        u_if.fire = 1'b1;
        @(negedge clk) resetn = 1'b1;
        idle_clks(3);
        check("fire_held_release", {31'd0, u_if.busy}, 0);
        u_if.fire = 1'b0;
        idle_clks(1);

        // Saturation: 256 quick hits, each aborted by hold after the grab.
        u_if.poro_x = 9'd49;
        for (int i = 1; i <= 256; i++) begin
            pulse_q.push_back(i < 255 ? i : 255);
            press_fire();
            frame_step();
            pulse_hold();
        end
        check("sat_count", {24'd0, u_if.grab_count}, 255);
        check("sat_busy",  {31'd0, u_if.busy}, 0);
        idle_clks(2);
        check("pulses_missing", 32'(pulse_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
